md_unit: RTL



---
 rtl/md_pkg.sv | 41 ++++
 rtl/md_unit_if.sv | 26 ++
 rtl/md_result_calc.sv | 86 ++++++++
 rtl/md_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// Optional feature macro: MD_UNIT_MADD_EN (enables MADD/MSUB accumulate ops).
package md_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MADD  = 4'd9,
        MSUB  = 4'd10
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // One bit per opcode: set for ops that occupy the unit for a full latency
`ifdef MD_UNIT_MADD_EN
    localparam logic [15:0] MD_ARITH_MASK = 16'h061E;
    localparam logic [15:0] MD_MUL_MASK   = 16'h0606;
`else
    localparam logic [15:0] MD_ARITH_MASK = 16'h001E;
    localparam logic [15:0] MD_MUL_MASK   = 16'h0006;
`endif

    function automatic logic isArith(input md_op_t op);
        return MD_ARITH_MASK[op];
    endfunction

    function automatic logic isMulClass(input md_op_t op);
        return MD_MUL_MASK[op];
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if #(parameter int WIDTH = 32);
    import md_pkg::*;

    logic             start;
    md_op_t           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, out
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, out
    );

endinterface

// File: rtl/md_result_calc.sv
// Combinational result generator: next {hi,lo} from latched op and operands.
// Optional feature macro: MD_UNIT_MADD_EN (adds MADD/MSUB accumulation).
module md_result_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_t           i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_divByZero
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]        w_sProd;
    logic [2*WIDTH-1:0]        w_uProd;
    logic                      w_divZero;
    logic                      w_overflow;
    logic [WIDTH-1:0]          w_uDivisor;
    logic [WIDTH-1:0]          w_uQuo;
    logic [WIDTH-1:0]          w_uRem;
    logic signed [WIDTH-1:0]   w_sDividend;
    logic signed [WIDTH-1:0]   w_sDivisor;
    logic signed [WIDTH-1:0]   w_sQuo;
    logic signed [WIDTH-1:0]   w_sRem;

    // Sign-extending both operands to 2*WIDTH makes a plain modular multiply
    // yield the exact signed product.
    assign w_sProd = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_uProd = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    assign w_divZero  = (i_b == '0);
    assign w_overflow = (i_a == MIN_VAL) && (i_b == '1);

    // A zero divisor is swapped for one so the divider never sees it; the
    // result is discarded anyway. MIN / -1 is rewritten as MIN / 1, which
    // gives exactly the wrapped answer wanted: quotient MIN, remainder 0.
    assign w_uDivisor  = w_divZero ? ONE : i_b;
    assign w_uQuo      = i_a / w_uDivisor;
    assign w_uRem      = i_a % w_uDivisor;

    assign w_sDividend = $signed(i_a);
    assign w_sDivisor  = $signed((w_divZero || w_overflow) ? ONE : i_b);
    assign w_sQuo      = w_sDividend / w_sDivisor;
    assign w_sRem      = w_sDividend % w_sDivisor;

    // Select the next HI/LO pair for the latched op; anything else keeps HI/LO
    always_comb begin
        o_hi        = i_hi;
        o_lo        = i_lo;
        o_divByZero = 1'b0;
        case (i_op)
            MULT:  {o_hi, o_lo} = w_sProd;
            MULTU: {o_hi, o_lo} = w_uProd;
            DIV: begin
                o_divByZero = w_divZero;
                if (!w_divZero) begin
                    o_hi = w_sRem;
                    o_lo = w_sQuo;
                end
            end
            DIVU: begin
                o_divByZero = w_divZero;
                if (!w_divZero) begin
                    o_hi = w_uRem;
                    o_lo = w_uQuo;
                end
            end
`ifdef MD_UNIT_MADD_EN
            MADD:  {o_hi, o_lo} = {i_hi, i_lo} + w_sProd;
            MSUB:  {o_hi, o_lo} = {i_hi, i_lo} - w_sProd;
`endif
            default: begin
                o_hi = i_hi;
                o_lo = i_lo;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Arithmetic ops hold busy for a class latency, then commit HI/LO and pulse done.
// Optional feature macro: MD_UNIT_MADD_EN (accepts MADD/MSUB, see md_pkg).
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        r_state;
    md_state_t        w_nextState;
    logic [CNT_W-1:0] r_count;
    md_op_t           r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_issue;
    logic             w_accept;
    logic             w_commit;
    logic             w_mthiWr;
    logic             w_mtloWr;
    logic [WIDTH-1:0] w_calcHi;
    logic [WIDTH-1:0] w_calcLo;
    logic             w_divByZero;
    logic [WIDTH-1:0] w_out;

    // A start only counts when no flush kills it in the same cycle
    assign w_issue = bus.start && !bus.flush;

    md_result_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .i_op        (r_op),
        .i_a         (r_a),
        .i_b         (r_b),
        .i_hi        (r_hi),
        .i_lo        (r_lo),
        .o_hi        (w_calcHi),
        .o_lo        (w_calcLo),
        .o_divByZero (w_divByZero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: enter RUN on an accepted arithmetic op, leave on flush or expiry
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue && isArith(bus.op)) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (bus.flush || (r_count == '0)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: issue/commit/move-to strobes; starts during RUN are ignored
    always_comb begin
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_mthiWr = 1'b0;
        w_mtloWr = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = w_issue && isArith(bus.op);
                w_mthiWr = w_issue && (bus.op == MTHI);
                w_mtloWr = w_issue && (bus.op == MTLO);
            end
            RUN: begin
                w_commit = !bus.flush && (r_count == '0);
            end
            default: ;
        endcase
    end

    // Operand latch, latency counter, HI/LO and the registered busy/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_op    <= NONE;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_busy <= (w_nextState == RUN);
            r_done <= w_commit;

            if (w_accept) begin
                r_op    <= bus.op;
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_count <= isMulClass(bus.op) ? MUL_LOAD : DIV_LOAD;
            end else if ((r_state == RUN) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end

            if (w_commit && !w_divByZero) begin
                r_hi <= w_calcHi;
                r_lo <= w_calcLo;
            end else begin
                if (w_mthiWr) begin
                    r_hi <= bus.a;
                end
                if (w_mtloWr) begin
                    r_lo <= bus.a;
                end
            end
        end
    end

    // Move-from read port: always shows the committed HI/LO, never a partial result
    always_comb begin
        w_out = '0;
        case (bus.op)
            MFHI:    w_out = r_hi;
            MFLO:    w_out = r_lo;
            default: w_out = '0;
        endcase
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.out  = w_out;

endmodule
